// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the memory copy engine.
package mem_copy_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;
  localparam int unsigned WORD_BYTES           = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/mem_copy_range_check.sv
// Combinational validation of a copy request against the target memory window.
// Only instantiated when MEM_COPY_RANGE_CHECK_EN is defined.
module mem_copy_range_check
  import mem_copy_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS),
  parameter int                    CNT_WIDTH    = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] Src_Address_i,
  input  logic [DATA_WIDTH-1:0] Dst_Address_i,
  input  logic [CNT_WIDTH-1:0]  Word_Count_i,
  output logic                  Range_Fail_o
);

  localparam logic [DATA_WIDTH:0] LIMIT = (DATA_WIDTH+1)'(MEMORY_DEPTH * WORD_BYTES);

  logic [DATA_WIDTH:0] span;
  logic                misaligned;
  logic                too_many;

  // One extra bit keeps offset+span from wrapping near the top of the address space.
  function automatic logic out_of_window(input logic [DATA_WIDTH-1:0] addr,
                                         input logic [DATA_WIDTH:0]   len);
    logic [DATA_WIDTH:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDRESS};
    return (addr < BASE_ADDRESS) || ((off + len) > LIMIT);
  endfunction

  assign span       = (DATA_WIDTH+1)'(Word_Count_i) << $clog2(WORD_BYTES);
  assign misaligned = (|Src_Address_i[1:0]) | (|Dst_Address_i[1:0]);
  assign too_many   = Word_Count_i > CNT_WIDTH'(MEMORY_DEPTH);

  assign Range_Fail_o = misaligned | too_many
                      | out_of_window(Src_Address_i, span)
                      | out_of_window(Dst_Address_i, span);

endmodule

// File: rtl/mem_copy_engine.sv
// Word-by-word block copy initiator on a single-port data memory.
// Optional request validation is enabled with MEM_COPY_RANGE_CHECK_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS),
  parameter int                    CNT_WIDTH    = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [DATA_WIDTH-1:0] Src_Address_i,
  input  logic [DATA_WIDTH-1:0] Dst_Address_i,
  input  logic [CNT_WIDTH-1:0]  Word_Count_i,
  input  logic [DATA_WIDTH-1:0] Read_Data_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  Write_Enable_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Error_o
);

  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(WORD_BYTES);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] src_q, src_d;
  logic [DATA_WIDTH-1:0] dst_q, dst_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  range_fail;

`ifdef MEM_COPY_RANGE_CHECK_EN
  logic err_q, err_d;

  mem_copy_range_check #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .BASE_ADDRESS (BASE_ADDRESS),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_range_check (
    .Src_Address_i (Src_Address_i),
    .Dst_Address_i (Dst_Address_i),
    .Word_Count_i  (Word_Count_i),
    .Range_Fail_o  (range_fail)
  );

  assign Error_o = err_q;
`else
  assign range_fail = 1'b0;
  assign Error_o    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
`ifdef MEM_COPY_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
`ifdef MEM_COPY_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
`ifdef MEM_COPY_RANGE_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Start_i) begin
          src_d = Src_Address_i;
          dst_d = Dst_Address_i;
          cnt_d = Word_Count_i;
`ifdef MEM_COPY_RANGE_CHECK_EN
          err_d = range_fail;
`endif
          // A rejected request skips straight to the completion pulse.
          if (range_fail || (Word_Count_i == '0)) state_d = DONE;
          else                                    state_d = READ;
        end
      end
      READ: begin
        buf_d   = Read_Data_i;
        src_d   = src_q + STEP;
        state_d = WRITE;
      end
      WRITE: begin
        dst_d   = dst_q + STEP;
        cnt_d   = cnt_q - CNT_WIDTH'(1);
        state_d = (cnt_q == CNT_WIDTH'(1)) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Address_o      = BASE_ADDRESS;
    Write_Data_o   = buf_q;
    Write_Enable_o = 1'b0;
    Busy_o         = 1'b0;
    Done_o         = 1'b0;
    unique case (state_q)
      IDLE: ;
      READ: begin
        Address_o = src_q;
        Busy_o    = 1'b1;
      end
      WRITE: begin
        Address_o      = dst_q;
        Write_Enable_o = 1'b1;
        Busy_o         = 1'b1;
      end
      DONE: begin
        Busy_o = 1'b1;
        Done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
